// File: rtl/cpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cpu_pkg                                                              |
// | Shared types for the instruction sequencer: opcode and state enums,  |
// | instruction field positions and opcode class helpers.                |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package cpu_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_LDI  = 4'h1,
    OP_MOV  = 4'h2,
    OP_ADD  = 4'h3,
    OP_SUB  = 4'h4,
    OP_AND  = 4'h5,
    OP_OR   = 4'h6,
    OP_XOR  = 4'h7,
    OP_NOT  = 4'h8,
    OP_SHL  = 4'h9,
    OP_SHR  = 4'hA,
    OP_JMP  = 4'hB,
    OP_JZ   = 4'hC,
    OP_JC   = 4'hD,
    OP_RSV  = 4'hE,
    OP_HALT = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RD_MSB  = 10;
  localparam int RD_LSB  = 8;
  localparam int RS_MSB  = 2;
  localparam int RS_LSB  = 0;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  // LDI..SHR produce a register result
  function automatic logic writes_gpr(input opcode_e op);
    return (op >= OP_LDI) && (op <= OP_SHR);
  endfunction

  // ADD..SHR are the only opcodes that touch the flags
  function automatic logic sets_flags(input opcode_e op);
    return (op >= OP_ADD) && (op <= OP_SHR);
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seq_ctrl_if                                                          |
// | Instruction-memory req/ack port and register-file port of the        |
// | sequencer. master = sequencer side, slave = memory/regfile side.     |
// |   imem_req/imem_addr  -> fetch request and address                   |
// |   imem_ack/imem_data  <- fetch acknowledge and instruction word      |
// |   gpr_rd_sel/rs_sel   -> register file read selects (rd is also the  |
// |                          write address)                              |
// |   gpr_load/gpr_wdata  -> register file write enable and data         |
// |   gpr_rd_val/rs_val   <- combinational read data                     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface seq_ctrl_if;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [15:0] imem_data;
  logic [2:0]  gpr_rd_sel;
  logic [2:0]  gpr_rs_sel;
  logic        gpr_load;
  logic [7:0]  gpr_wdata;
  logic [7:0]  gpr_rd_val;
  logic [7:0]  gpr_rs_val;

  modport master (
    output imem_req, imem_addr, gpr_rd_sel, gpr_rs_sel, gpr_load, gpr_wdata,
    input  imem_ack, imem_data, gpr_rd_val, gpr_rs_val
  );

  modport slave (
    input  imem_req, imem_addr, gpr_rd_sel, gpr_rs_sel, gpr_load, gpr_wdata,
    output imem_ack, imem_data, gpr_rd_val, gpr_rs_val
  );
endinterface
`default_nettype wire

// File: rtl/ctrl_alu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ctrl_alu                                                             |
// | Combinational 8-bit ALU for the sequencer.                           |
// |   op     : opcode                                                    |
// |   a, b   : first / second operand (b carries imm for LDI)             |
// |   c_in   : current carry, passed through for non-flag opcodes        |
// |   result : 8-bit result, z : result==0, c : next carry               |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module ctrl_alu
  import cpu_pkg::*;
(
  input  opcode_e    op,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       c_in,
  output logic [7:0] result,
  output logic       z,
  output logic       c
);

  logic [8:0] sum;

  always_comb begin
    sum    = {1'b0, a} + {1'b0, b};
    result = 8'h00;
    c      = c_in;
    case (op)
      OP_LDI, OP_MOV: result = b;
      OP_ADD: begin
        result = sum[7:0];
        c      = sum[8];
      end
      OP_SUB: begin
        result = a - b;
        c      = (a < b);
      end
      OP_AND: begin
        result = a & b;
        c      = 1'b0;
      end
      OP_OR: begin
        result = a | b;
        c      = 1'b0;
      end
      OP_XOR: begin
        result = a ^ b;
        c      = 1'b0;
      end
      OP_NOT: begin
        result = ~a;
        c      = 1'b0;
      end
      OP_SHL: begin
        result = {a[6:0], 1'b0};
        c      = a[7];
      end
      OP_SHR: begin
        result = {1'b0, a[7:1]};
        c      = a[0];
      end
      default: begin
        result = 8'h00;
        c      = c_in;
      end
    endcase
    z = (result == 8'h00);
  end

endmodule
`default_nettype wire

// File: rtl/seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seq_ctrl                                                             |
// | Multi-cycle instruction sequencer: FETCH, DECODE, EXEC, WB.          |
// |   clk, rst_n : clock, asynchronous active-low reset                  |
// |   run        : start/resume, sampled in IDLE and HALT                |
// |   bus        : memory and register-file ports (seq_ctrl_if.master)   |
// |   pc         : program counter (also drives imem_addr)               |
// |   flag_z/c   : committed zero / carry flags                          |
// |   halted     : high in IDLE and HALT                                 |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module seq_ctrl
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  seq_ctrl_if.master        bus,
  output logic [7:0]        pc,
  output logic              flag_z,
  output logic              flag_c,
  output logic              halted
);

  state_e      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic [7:0]  pc_q, pc_d;
  logic        z_q, z_d, c_q, c_d;
  logic [7:0]  res_q, res_d;
  logic        nz_q, nz_d, nc_q, nc_d;
  logic        req_q, req_d;
  logic        load_q, load_d;
  logic [2:0]  rd_sel_q, rd_sel_d, rs_sel_q, rs_sel_d;
  logic        halted_q, halted_d;

  opcode_e     op_ir;
  logic [7:0]  imm_ir;
  logic [7:0]  alu_b;
  logic [7:0]  alu_res;
  logic        alu_z, alu_c;
  logic        unused_ir_bit;

  assign op_ir  = opcode_e'(ir_q[OP_MSB:OP_LSB]);
  assign imm_ir = ir_q[IMM_MSB:IMM_LSB];
  // ir[11] has no meaning in this instruction set
  assign unused_ir_bit = ir_q[11];

  // LDI shares the ALU pass-through path with MOV, fed from the immediate
  assign alu_b = (op_ir == OP_LDI) ? imm_ir : bus.gpr_rs_val;

  ctrl_alu u_alu (
    .op     (op_ir),
    .a      (bus.gpr_rd_val),
    .b      (alu_b),
    .c_in   (c_q),
    .result (alu_res),
    .z      (alu_z),
    .c      (alu_c)
  );

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    pc_d    = pc_q;
    z_d     = z_q;
    c_d     = c_q;
    res_d   = res_q;
    nz_d    = nz_q;
    nc_d    = nc_q;

    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (bus.imem_ack) begin
          ir_d    = bus.imem_data;
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        res_d   = alu_res;
        nz_d    = alu_z;
        nc_d    = alu_c;
        state_d = S_WB;
      end
      S_WB: begin
        if (sets_flags(op_ir)) begin
          z_d = nz_q;
          c_d = nc_q;
        end
        state_d = S_FETCH;
        case (op_ir)
          OP_JMP:  pc_d = imm_ir;
          OP_JZ:   pc_d = z_q ? imm_ir : pc_q + 8'd1;
          OP_JC:   pc_d = c_q ? imm_ir : pc_q + 8'd1;
          OP_HALT: state_d = S_HALT;
          default: pc_d = pc_q + 8'd1;
        endcase
      end
      S_HALT: begin
        if (run) begin
          pc_d    = pc_q + 8'd1;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered: derive them from the state being entered
    req_d    = (state_d == S_FETCH);
    load_d   = (state_d == S_WB) && writes_gpr(op_ir);
    halted_d = (state_d == S_IDLE) || (state_d == S_HALT);
    if ((state_d == S_DECODE) || (state_d == S_EXEC) || (state_d == S_WB)) begin
      rd_sel_d = ir_d[RD_MSB:RD_LSB];
      rs_sel_d = ir_d[RS_MSB:RS_LSB];
    end else begin
      rd_sel_d = 3'd0;
      rs_sel_d = 3'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      ir_q     <= 16'h0000;
      pc_q     <= 8'h00;
      z_q      <= 1'b0;
      c_q      <= 1'b0;
      res_q    <= 8'h00;
      nz_q     <= 1'b0;
      nc_q     <= 1'b0;
      req_q    <= 1'b0;
      load_q   <= 1'b0;
      rd_sel_q <= 3'd0;
      rs_sel_q <= 3'd0;
      halted_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      pc_q     <= pc_d;
      z_q      <= z_d;
      c_q      <= c_d;
      res_q    <= res_d;
      nz_q     <= nz_d;
      nc_q     <= nc_d;
      req_q    <= req_d;
      load_q   <= load_d;
      rd_sel_q <= rd_sel_d;
      rs_sel_q <= rs_sel_d;
      halted_q <= halted_d;
    end
  end

  assign bus.imem_req   = req_q;
  assign bus.imem_addr  = pc_q;
  assign bus.gpr_rd_sel = rd_sel_q;
  assign bus.gpr_rs_sel = rs_sel_q;
  assign bus.gpr_load   = load_q;
  assign bus.gpr_wdata  = res_q;
  assign pc             = pc_q;
  assign flag_z         = z_q;
  assign flag_c         = c_q;
  assign halted         = halted_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_seq_ctrl                                                          |
// | Self-checking bench for seq_ctrl with an instruction memory, a       |
// | register file and an instruction-level reference model.              |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_seq_ctrl;

  typedef struct packed {
    logic [2:0] sel;
    logic [7:0] data;
  } exp_t;

  typedef struct {
    logic [3:0] op;
    logic [2:0] rs;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp_r;
    logic       exp_z;
    logic       exp_c;
    string      name;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic [7:0]  pc;
  logic        flag_z, flag_c, halted;

  int          checks = 0;
  int          errors = 0;
  int          ack_delay = 0;
  int          wait_cnt;

  logic [15:0] imem [0:255];
  logic [7:0]  rf   [0:7];
  logic [7:0]  mrf  [0:7];
  logic [7:0]  m_pc;
  logic        m_z, m_c, m_idle;
  exp_t        exp_q [$];
  exp_t        mon_e;
  logic        prev_load = 1'b0;
  vec_t        vt [11];

  seq_ctrl_if bus ();

  seq_ctrl dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .run    (run),
    .bus    (bus),
    .pc     (pc),
    .flag_z (flag_z),
    .flag_c (flag_c),
    .halted (halted)
  );

  always #5 clk = ~clk;

  // Memory: ack after ack_delay cycles of request (0 = same cycle)
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) wait_cnt <= 0;
    else if (bus.imem_req && !bus.imem_ack) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end
  assign bus.imem_ack  = bus.imem_req && (wait_cnt >= ack_delay);
  assign bus.imem_data = imem[bus.imem_addr];

  // Register file: combinational reads, write on clock edge
  always @(posedge clk) if (bus.gpr_load) rf[bus.gpr_rd_sel] <= bus.gpr_wdata;
  assign bus.gpr_rd_val = rf[bus.gpr_rd_sel];
  assign bus.gpr_rs_val = rf[bus.gpr_rs_sel];

  // Scoreboard: every write-back pulse is matched against the model queue
  always @(negedge clk) begin
    if (rst_n && bus.gpr_load) begin
      checks++;
      if (prev_load) begin
        errors++;
        $display("FAIL load_pulse: gpr_load high 2+ cycles, required 1");
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wb_unexpected: sel=%0d data=%02h, required no write",
                 bus.gpr_rd_sel, bus.gpr_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        if (bus.gpr_rd_sel !== mon_e.sel || bus.gpr_wdata !== mon_e.data) begin
          errors++;
          $display("FAIL wb_data: sel=%0d data=%02h, required sel=%0d data=%02h",
                   bus.gpr_rd_sel, bus.gpr_wdata, mon_e.sel, mon_e.data);
        end
      end
    end
    prev_load = bus.gpr_load;
  end

  function automatic logic [15:0] ins(input logic [3:0] op, input logic [2:0] rd,
                                      input logic [7:0] lo);
    return {op, 1'b0, rd, lo};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  // Instruction-level reference: runs from spc to HALT, queues expected writes
  task automatic model_exec(input logic [7:0] spc);
    logic [7:0]  p, a, b, imm, r;
    logic [15:0] w;
    logic [3:0]  op;
    logic [2:0]  rd, rs;
    logic [8:0]  s;
    logic        done, wr;
    p = spc;
    done = 1'b0;
    for (int n = 0; n < 500 && !done; n++) begin
      w = imem[p]; op = w[15:12]; rd = w[10:8]; rs = w[2:0]; imm = w[7:0];
      a = mrf[rd]; b = mrf[rs]; r = 8'h00; wr = 1'b1;
      case (op)
        4'h1: r = imm;
        4'h2: r = b;
        4'h3: begin s = {1'b0, a} + {1'b0, b}; r = s[7:0]; m_c = s[8]; end
        4'h4: begin r = a - b; m_c = (a < b); end
        4'h5: begin r = a & b; m_c = 1'b0; end
        4'h6: begin r = a | b; m_c = 1'b0; end
        4'h7: begin r = a ^ b; m_c = 1'b0; end
        4'h8: begin r = ~a; m_c = 1'b0; end
        4'h9: begin m_c = a[7]; r = a << 1; end
        4'hA: begin m_c = a[0]; r = a >> 1; end
        default: wr = 1'b0;
      endcase
      if (op >= 4'h3 && op <= 4'hA) m_z = (r == 8'h00);
      if (wr) begin
        exp_q.push_back('{sel: rd, data: r});
        mrf[rd] = r;
      end
      case (op)
        4'hB: p = imm;
        4'hC: p = m_z ? imm : p + 8'd1;
        4'hD: p = m_c ? imm : p + 8'd1;
        4'hF: done = 1'b1;
        default: p = p + 8'd1;
      endcase
    end
    m_pc = p;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    run = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_pc = 8'h00; m_z = 1'b0; m_c = 1'b0; m_idle = 1'b1;
  endtask

  task automatic go();
    @(negedge clk);
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
  endtask

  task automatic wait_halt(input int budget, output int cyc);
    cyc = 0;
    while (!halted && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (!halted) begin
      errors++;
      $display("FAIL halt_timeout: halted=0 after %0d cycles, required 1", cyc);
    end
  endtask

  task automatic do_prog(input string nm, output int cyc);
    model_exec(m_idle ? m_pc : m_pc + 8'd1);
    m_idle = 1'b0;
    go();
    wait_halt(300, cyc);
    chk({nm, "_pc"}, pc, m_pc);
    chk({nm, "_z"}, flag_z, m_z);
    chk({nm, "_c"}, flag_c, m_c);
    chk({nm, "_drain"}, exp_q.size(), 0);
  endtask

  initial begin
    int cyc;
    logic [7:0] base;

    vt[0]  = '{4'h3, 3'd2, 8'hF0, 8'h20, 8'h10, 1'b0, 1'b1, "add_carry"};
    vt[1]  = '{4'h4, 3'd1, 8'h10, 8'h00, 8'h00, 1'b1, 1'b0, "sub_self"};
    vt[2]  = '{4'h4, 3'd2, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b1, "sub_borrow"};
    vt[3]  = '{4'h3, 3'd2, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1, "add_wrap"};
    vt[4]  = '{4'h5, 3'd2, 8'hCC, 8'hAA, 8'h88, 1'b0, 1'b0, "and"};
    vt[5]  = '{4'h6, 3'd2, 8'hC0, 8'h0A, 8'hCA, 1'b0, 1'b0, "or"};
    vt[6]  = '{4'h7, 3'd2, 8'hFF, 8'hFF, 8'h00, 1'b1, 1'b0, "xor"};
    vt[7]  = '{4'h8, 3'd2, 8'h0F, 8'h00, 8'hF0, 1'b0, 1'b0, "not"};
    vt[8]  = '{4'h9, 3'd2, 8'h81, 8'h00, 8'h02, 1'b0, 1'b1, "shl"};
    vt[9]  = '{4'hA, 3'd2, 8'h01, 8'h00, 8'h00, 1'b1, 1'b1, "shr"};
    vt[10] = '{4'h2, 3'd2, 8'h00, 8'h3C, 8'h3C, 1'b1, 1'b1, "mov_keeps_flags"};

    for (int i = 0; i < 256; i++) imem[i] = 16'h0000;
    for (int i = 0; i < 8; i++) mrf[i] = 8'h00;

    // Reset values
    do_reset();
    chk("rst_req", bus.imem_req, 0);
    chk("rst_load", bus.gpr_load, 0);
    chk("rst_rd_sel", bus.gpr_rd_sel, 0);
    chk("rst_rs_sel", bus.gpr_rs_sel, 0);
    chk("rst_wdata", bus.gpr_wdata, 0);
    chk("rst_pc", pc, 0);
    chk("rst_addr", bus.imem_addr, 0);
    chk("rst_flags", {flag_z, flag_c}, 0);
    chk("rst_halted", halted, 1);

    // LDI r3,0x5A ; HALT -- 8 cycles from run
    imem[0] = ins(4'h1, 3'd3, 8'h5A);
    imem[1] = ins(4'hF, 3'd0, 8'h00);
    do_prog("ldi_halt", cyc);
    chk("ldi_halt_cycles", cyc, 8);
    chk("ldi_halt_pc_abs", pc, 8'h01);
    chk("ldi_halt_rf3", rf[3], 8'h5A);

    // ALU table: LDI r1,a ; LDI r2,b ; OP r1,rs ; HALT
    for (int i = 0; i < 11; i++) begin
      base = m_pc + 8'd1;
      imem[base]        = ins(4'h1, 3'd1, vt[i].a);
      imem[base + 8'd1] = ins(4'h1, 3'd2, vt[i].b);
      imem[base + 8'd2] = ins(vt[i].op, 3'd1, {5'd0, vt[i].rs});
      imem[base + 8'd3] = ins(4'hF, 3'd0, 8'h00);
      do_prog(vt[i].name, cyc);
      chk({vt[i].name, "_res"}, rf[1], vt[i].exp_r);
      chk({vt[i].name, "_zexp"}, flag_z, vt[i].exp_z);
      chk({vt[i].name, "_cexp"}, flag_c, vt[i].exp_c);
    end

    // Jumps: JZ/JC not taken, JZ taken, JMP/NOP wrap at 0xFF
    base = m_pc + 8'd1;
    imem[base]        = ins(4'h1, 3'd1, 8'h01);
    imem[base + 8'd1] = ins(4'h1, 3'd2, 8'h01);
    imem[base + 8'd2] = ins(4'h3, 3'd1, 8'h02);
    imem[base + 8'd3] = ins(4'hC, 3'd0, 8'h40);
    imem[base + 8'd4] = ins(4'hD, 3'd0, 8'h40);
    imem[base + 8'd5] = ins(4'hF, 3'd0, 8'h00);
    imem[base + 8'd6] = ins(4'h4, 3'd1, 8'h01);
    imem[base + 8'd7] = ins(4'hC, 3'd0, 8'h40);
    imem[8'h40] = ins(4'hF, 3'd0, 8'h00);
    imem[8'h41] = ins(4'hB, 3'd0, 8'hFF);
    imem[8'hFF] = ins(4'h0, 3'd0, 8'h00);
    imem[8'h00] = ins(4'hF, 3'd0, 8'h00);
    do_prog("jz_not_taken", cyc);
    chk("jz_not_taken_abs", pc, base + 8'd5);
    do_prog("jz_taken", cyc);
    chk("jz_taken_abs", pc, 8'h40);
    do_prog("nop_wrap", cyc);
    chk("nop_wrap_abs", pc, 8'h00);
    imem[8'h01] = ins(4'hB, 3'd0, 8'hFF);
    imem[8'hFF] = ins(4'hB, 3'd0, 8'h00);
    do_prog("jmp_at_ff", cyc);
    chk("jmp_at_ff_abs", pc, 8'h00);

    // Fetch wait states: ack 3 cycles late, ir must come from the ack cycle
    do_reset();
    ack_delay = 3;
    imem[0] = ins(4'h1, 3'd2, 8'hEE);
    imem[1] = ins(4'hF, 3'd0, 8'h00);
    exp_q.push_back('{sel: 3'd5, data: 8'h33});
    go();
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      chk("ws_req_held", bus.imem_req, 1);
      chk("ws_addr_stable", bus.imem_addr, 0);
      if (i == 2) imem[0] = ins(4'h1, 3'd5, 8'h33);
    end
    @(negedge clk);
    chk("ws_req_drop", bus.imem_req, 0);
    chk("ws_ir_on_ack", bus.gpr_rd_sel, 5);
    wait_halt(100, cyc);
    chk("ws_pc", pc, 8'h01);
    chk("ws_rf5", rf[5], 8'h33);
    ack_delay = 0;
    m_pc = 8'h01; m_idle = 1'b0; mrf[5] = 8'h33;

    // Reset during WB: r6 holds 0x11, the interrupted write of 0x99 is lost
    imem[2] = ins(4'h1, 3'd6, 8'h11);
    imem[3] = ins(4'hF, 3'd0, 8'h00);
    do_prog("r6_init", cyc);
    do_reset();
    imem[0] = ins(4'h1, 3'd6, 8'h99);
    exp_q.push_back('{sel: 3'd6, data: 8'h99});
    go();
    cyc = 0;
    while (!bus.gpr_load && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("rwb_reached_wb", bus.gpr_load, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rwb_load_drop", bus.gpr_load, 0);
    chk("rwb_req", bus.imem_req, 0);
    chk("rwb_halted", halted, 1);
    chk("rwb_pc", pc, 0);
    chk("rwb_wdata", bus.gpr_wdata, 0);
    chk("rwb_sels", {bus.gpr_rd_sel, bus.gpr_rs_sel}, 0);
    @(posedge clk);
    #1;
    chk("rwb_no_write", rf[6], 8'h11);
    @(negedge clk);
    rst_n = 1'b1;
    m_pc = 8'h00; m_z = 1'b0; m_c = 1'b0; m_idle = 1'b1;

    // HALT at 5, run held high: one resume to 6, then LDI and HALT at 7
    for (int i = 0; i < 5; i++) imem[i] = 16'h0000;
    imem[5] = ins(4'hF, 3'd0, 8'h00);
    imem[6] = ins(4'h1, 3'd4, 8'h77);
    imem[7] = ins(4'hF, 3'd0, 8'h00);
    do_prog("halt5", cyc);
    chk("halt5_abs", pc, 8'h05);
    exp_q.push_back('{sel: 3'd4, data: 8'h77});
    @(negedge clk);
    run = 1'b1;
    @(negedge clk);
    chk("resume_pc", pc, 8'h06);
    chk("resume_running", halted, 0);
    repeat (2) @(negedge clk);
    run = 1'b0;
    wait_halt(100, cyc);
    chk("resume_final_pc", pc, 8'h07);
    chk("resume_rf4", rf[4], 8'h77);

    repeat (2) @(negedge clk);
    chk("sb_final_drain", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
